// File: rtl/instr_stream_loader.sv
// instr_stream_loader: packs three host stream words into one 80-bit TPU instruction write (INSTR_LOADER_COUNT_EN adds an issue counter)
module instr_stream_loader #(
    parameter int UPPER_WORD_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        flush,
    input  logic                        instr_fifo_full,
    output logic [31:0]                 lower_instr_word,
    output logic [31:0]                 middle_instr_word,
    output logic [UPPER_WORD_WIDTH-1:0] upper_instr_word,
    output logic [2:0]                  instr_write_enable,
    output logic                        busy,
    output logic [31:0]                 issued_count
);
    typedef enum logic [1:0] {W0, W1, W2, ISSUE} state_t;
    state_t                        r_state;
    logic [31:0]                   r_lower;
    logic [31:0]                   r_middle;
    logic [UPPER_WORD_WIDTH-1:0]   r_upper;
    logic                          w_accept;
    logic                          w_issue;
    assign s_ready            = (r_state != ISSUE) && !flush && !rst;
    assign w_accept           = s_valid && s_ready;
    assign w_issue            = (r_state == ISSUE) && !instr_fifo_full && !flush && !rst;
    assign instr_write_enable = w_issue ? 3'b111 : 3'b000;
    assign busy               = r_state != W0;
    assign lower_instr_word   = r_lower;
    assign middle_instr_word  = r_middle;
    assign upper_instr_word   = r_upper;
    // Capture words in order, then wait in ISSUE until the FIFO can take the instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= W0;
            r_lower  <= '0;
            r_middle <= '0;
            r_upper  <= '0;
        end else if (flush) begin
            r_state <= W0;
        end else begin
            case (r_state)
                W0:    if (w_accept) begin r_lower  <= s_data; r_state <= W1; end
                W1:    if (w_accept) begin r_middle <= s_data; r_state <= W2; end
                W2:    if (w_accept) begin r_upper  <= s_data[UPPER_WORD_WIDTH-1:0]; r_state <= ISSUE; end
                ISSUE: if (!instr_fifo_full) r_state <= W0;
            endcase
        end
    end
`ifdef INSTR_LOADER_COUNT_EN
    logic [31:0] r_issued_count;
    // Count every completed FIFO write; wraps naturally and survives flush
    always_ff @(posedge clk) begin
        if (rst) r_issued_count <= '0;
        else if (w_issue) r_issued_count <= r_issued_count + 32'd1;
    end
    assign issued_count = r_issued_count;
`else
    assign issued_count = '0;
`endif
endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: scoreboard bench for the instruction stream loader
module tb_instr_stream_loader;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] s_data = '0;
    logic        s_valid = 0;
    logic        s_ready;
    logic        flush = 0;
    logic        instr_fifo_full = 0;
    logic [31:0] lower_instr_word;
    logic [31:0] middle_instr_word;
    logic [15:0] upper_instr_word;
    logic [2:0]  instr_write_enable;
    logic        busy;
    logic [31:0] issued_count;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [79:0] sb_q[$];
    logic [79:0] part = '0;
    int          widx = 0;
    int          exp_issued = 0;
    int          cyc = 0;
    int          strobe_cycs[$];
    int          low_cnt = 0;
    bit          mon_on = 0;

    instr_stream_loader #(.UPPER_WORD_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .instr_fifo_full(instr_fifo_full),
        .lower_instr_word(lower_instr_word), .middle_instr_word(middle_instr_word),
        .upper_instr_word(upper_instr_word), .instr_write_enable(instr_write_enable),
        .busy(busy), .issued_count(issued_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef INSTR_LOADER_COUNT_EN
        return 32'(exp_issued);
`else
        return 32'd0;
`endif
    endfunction

    // Strobe monitor: every write must be a full write matching the oldest expected instruction
    always @(negedge clk) begin
        logic [79:0] e;
        if (mon_on && !s_ready) low_cnt++;
        if (instr_write_enable != 3'b000) begin
            strobe_cycs.push_back(cyc);
            check("we_with_full", instr_fifo_full, 0);
            check("we_all", instr_write_enable, 3'b111);
            if (sb_q.size() == 0) check("sb_unexpected", 1, 0);
            else begin
                e = sb_q.pop_front();
                check("sb_instr", {upper_instr_word, middle_instr_word, lower_instr_word}, e);
            end
        end
    end

    task automatic send_word(input logic [31:0] d);
        int t = 0;
        s_data = d;
        s_valid = 1;
        do begin @(negedge clk); t++; end while (!s_ready && t < 50);
        if (!s_ready) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 0;
        if (widx == 0) part[31:0] = d;
        else if (widx == 1) part[63:32] = d;
        else part[79:64] = d[15:0];
        widx++;
        if (widx == 3) begin sb_q.push_back(part); widx = 0; end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_we", instr_write_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_words", {upper_instr_word, middle_instr_word, lower_instr_word}, 0);
        check("rst_cnt", issued_count, 0);
        step();
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", s_ready, 1);
        step();
        // Basic issue
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'hABCD_3333);
        exp_issued++;
        @(negedge clk);
        check("basic_we", instr_write_enable, 3'b111);
        check("basic_lower", lower_instr_word, 32'h1111_1111);
        check("basic_middle", middle_instr_word, 32'h2222_2222);
        check("basic_upper", upper_instr_word, 16'h3333);
        check("basic_ready_issue", s_ready, 0);
        step();
        check("basic_cnt", issued_count, cnt_exp());
        check("basic_busy_after", busy, 0);
        // Back-to-back
        strobe_cycs.delete();
        low_cnt = 0;
        mon_on = 1;
        for (int i = 0; i < 9; i++) send_word($urandom);
        @(negedge clk);
        step();
        mon_on = 0;
        exp_issued += 3;
        check("b2b_strobes", strobe_cycs.size(), 3);
        if (strobe_cycs.size() == 3) begin
            check("b2b_gap1", strobe_cycs[1] - strobe_cycs[0], 4);
            check("b2b_gap2", strobe_cycs[2] - strobe_cycs[1], 4);
        end
        check("b2b_ready_low", low_cnt, 3);
        check("b2b_cnt", issued_count, cnt_exp());
        // FIFO full stall
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        instr_fifo_full = 1;
        send_word(32'h5555_0003);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_ready", s_ready, 0);
            check("full_we", instr_write_enable, 0);
            check("full_busy", busy, 1);
            step();
        end
        instr_fifo_full = 0;
        exp_issued++;
        @(negedge clk);
        check("full_release_we", instr_write_enable, 3'b111);
        check("full_words", {upper_instr_word, middle_instr_word, lower_instr_word}, 80'h0003_CAFE0002_CAFE0001);
        step();
        check("full_cnt", issued_count, cnt_exp());
        // Flush after two words
        send_word(32'hDEAD_0001);
        send_word(32'hDEAD_0002);
        s_data = 32'hBAD0_BAD0;
        s_valid = 1;
        flush = 1;
        @(negedge clk);
        check("flush_ready", s_ready, 0);
        check("flush_we", instr_write_enable, 0);
        step();
        flush = 0;
        s_valid = 0;
        widx = 0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        check("flush_keep_lower", lower_instr_word, 32'hDEAD_0001);
        step();
        send_word(32'h0101_0101);
        send_word(32'h0202_0202);
        send_word(32'hFFFF_0303);
        exp_issued++;
        @(negedge clk);
        check("post_flush_we", instr_write_enable, 3'b111);
        step();
        // Flush in ISSUE with FIFO not full
        send_word(32'h7777_0001);
        send_word(32'h7777_0002);
        send_word(32'h7777_0003);
        void'(sb_q.pop_back());
        flush = 1;
        @(negedge clk);
        check("flush_issue_we", instr_write_enable, 0);
        step();
        flush = 0;
        @(negedge clk);
        check("flush_issue_busy", busy, 0);
        check("flush_issue_cnt", issued_count, cnt_exp());
        step();
        // Counter wrap or tie-off
`ifdef INSTR_LOADER_COUNT_EN
        force dut.r_issued_count = 32'hFFFF_FFFF;
        @(negedge clk);
        check("cnt_forced", issued_count, 32'hFFFF_FFFF);
        release dut.r_issued_count;
        step();
        send_word(32'h0000_00A1);
        send_word(32'h0000_00A2);
        send_word(32'h0000_00A3);
        @(negedge clk);
        step();
        check("cnt_wrap", issued_count, 0);
`else
        check("cnt_tied", issued_count, 0);
`endif
        // Reset mid-operation in ISSUE
        send_word(32'h9999_0001);
        send_word(32'h9999_0002);
        send_word(32'h9999_0003);
        void'(sb_q.pop_back());
        rst = 1;
        @(negedge clk);
        check("rst_mid_we", instr_write_enable, 0);
        check("rst_mid_ready", s_ready, 0);
        step();
        exp_issued = 0;
        @(negedge clk);
        check("rst_mid_words", {upper_instr_word, middle_instr_word, lower_instr_word}, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cnt", issued_count, 0);
        step();
        rst = 0;
        @(negedge clk);
        check("rst_mid_ready_after", s_ready, 1);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_stream_loader.md
# instr_stream_loader

Host-side instruction packer sitting directly upstream of the TPU top-level instruction write port. Accepts a stream of 32-bit words from the host over a valid/ready handshake. Assembles each group of three words into one 80-bit instruction (lower 32, middle 32, upper 16). Writes the completed instruction into the TPU instruction FIFO in a single cycle, stalling while that FIFO reports full.

## Interface
Parameters:
- `UPPER_WORD_WIDTH`, default 16: number of bits taken from the third stream word; the remaining upper bits of that word are ignored.

Ports:
- `clk`  in  1  clock. One clock domain; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  32  host stream word.
- `s_valid`  in  1  host word valid.
- `s_ready`  out  1  loader can accept a word this cycle.
- `flush`  in  1  synchronous abort: discards any partially assembled or pending instruction.
- `instr_fifo_full`  in  1  full flag from the TPU instruction FIFO.
- `lower_instr_word`  out  32  instruction bits [31:0].
- `middle_instr_word`  out  32  instruction bits [63:32].
- `upper_instr_word`  out  UPPER_WORD_WIDTH  instruction bits [79:64].
- `instr_write_enable`  out  3  per-word write strobes to the FIFO (bit0 lower, bit1 middle, bit2 upper).
- `busy`  out  1  a partial or pending instruction is held.
- `issued_count`  out  32  number of instructions written to the FIFO (see Configuration).

## Operation
- State machine `W0 → W1 → W2 → ISSUE → W0`.
- **W0**: on handshake (`s_valid && s_ready`), register `s_data` into `lower_instr_word`, go to W1.
- **W1**: on handshake, register into `middle_instr_word`, go to W2.
- **W2**: on handshake, register `s_data[UPPER_WORD_WIDTH-1:0]` into `upper_instr_word`, go to ISSUE.
- **ISSUE**:
  - `s_ready`=0.
  - If `instr_fifo_full`=0: drive `instr_write_enable`=3'b111 for exactly this cycle and go to W0.
  - Otherwise hold in ISSUE with strobes 3'b000.
- `s_ready` = (state != ISSUE) && !flush && !rst. It is combinational from state and `flush`.
- `instr_write_enable` is 3'b000 in every state except the issuing ISSUE cycle. Partial strobes (001, 011, …) are never generated.
- Word registers change only on their own capture. Between captures they hold their previous contents, so stale data is visible but never strobed.
- `busy` = (state != W0).
- **Flush**:
  - Next state is W0 from any state, and `flush` takes priority over the handshake; a word offered in the flush cycle is not accepted.
  - A flush in ISSUE with FIFO not full also suppresses the write: strobes are 3'b000 and the instruction is lost.
  - Word registers are not cleared by flush.
- No `s_valid` in W0/W1/W2: the loader holds state indefinitely; there is no timeout.

## Timing
- Reset values:
  - state W0
  - all word outputs 0
  - `instr_write_enable` 3'b000
  - `busy` 0
  - `issued_count` 0
  - `s_ready` 0 during the reset cycle, 1 in the first cycle after.
- Latency: third word accepted at edge N → strobe 3'b111 in cycle N+1 (if not full). Strobe cycle k+1 lands at edge N+1+k after k full cycles.
- Throughput: at most one instruction per 4 cycles (3 accept + 1 issue).
- `instr_fifo_full` is sampled only in ISSUE. It is combinationally used in the issuing cycle, so the strobe and the full flag are never asserted together.
- Reset mid-operation (any state, including ISSUE with full low): no strobe that cycle, everything returns to reset values on the next edge.

## Configuration
- `INSTR_LOADER_COUNT_EN` defined: `issued_count` increments by 1 on every cycle with `instr_write_enable`=3'b111. It wraps from 32'hFFFF_FFFF to 0 and is cleared only by `rst` (not by `flush`).
- Undefined: `issued_count` is tied to 0 and no counter register exists.

## Test plan
- **Basic issue.** Reset, then stream 32'h1111_1111, 32'h2222_2222, 32'hABCD_3333 with `s_valid` held, full=0 → strobe 3'b111 one cycle after the third accept, with lower=32'h1111_1111, middle=32'h2222_2222, upper=16'h3333. Count becomes 1 when enabled.
- **Back-to-back.** Stream 9 words continuously → exactly 3 strobes, spaced 4 cycles apart. `s_ready` is low only in the 3 ISSUE cycles.
- **FIFO full.** Hold `instr_fifo_full`=1 for 5 cycles after the third word → `s_ready`=0 and no strobe for 5 cycles. A single strobe follows in the cycle full drops, and word values are unchanged.
- **Flush.**
  - Flush after 2 words → state W0, `busy`=0, no strobe. The next 3 words form a correct instruction.
  - Flush in ISSUE with full=0 → no strobe, and the count is unchanged.
- **Reset mid-operation.** Assert `rst` in ISSUE → no strobe. All outputs read 0 the next cycle, and `s_ready` returns to 1 after release.
- **Counter wrap** (macro defined). Force `issued_count` to 32'hFFFF_FFFF, issue one instruction → `issued_count`=0. With the macro undefined, the output stays 0 throughout.
